// File: rtl/datapath_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/HALT controller for a register-file + ALU datapath.
// Optional feature macro DATAPATH_CTRL_CALL_EN adds CALL/RET with a 4-entry return stack.
module datapath_ctrl (
   input  logic        clk,
   input  logic        rst,
   output logic        instr_req,
   output logic [7:0]  instr_addr,
   input  logic        instr_valid,
   input  logic [15:0] instr_data,
   input  logic        alu_zero,
   input  logic        alu_carry,
   output logic [2:0]  alu_opcode,
   output logic [3:0]  ra_addr,
   output logic [3:0]  rb_addr,
   output logic [3:0]  write_addr,
   output logic [7:0]  write_data,
   output logic        wb_sel,
   output logic        write_en,
   output logic        halted
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_e;

   localparam logic [3:0] OP_LDI  = 4'b0001;
   localparam logic [3:0] OP_JMP  = 4'b0010;
   localparam logic [3:0] OP_JZ   = 4'b0011;
   localparam logic [3:0] OP_JC   = 4'b0100;
   localparam logic [3:0] OP_HALT = 4'b0111;
`ifdef DATAPATH_CTRL_CALL_EN
   localparam logic [3:0] OP_CALL = 4'b0101;
   localparam logic [3:0] OP_RET  = 4'b0110;
`endif

   state_e      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic        z_q, z_d;
   logic        c_q, c_d;
   logic        instr_req_q, instr_req_d;
   logic [2:0]  alu_opcode_q, alu_opcode_d;
   logic [3:0]  ra_addr_q, ra_addr_d;
   logic [3:0]  rb_addr_q, rb_addr_d;
   logic [3:0]  write_addr_q, write_addr_d;
   logic [7:0]  write_data_q, write_data_d;
   logic        wb_sel_q, wb_sel_d;
   logic        write_en_q, write_en_d;
   logic        halted_q, halted_d;
`ifdef DATAPATH_CTRL_CALL_EN
   logic [2:0]  sp_q, sp_d;          // number of live entries, 0..4
   logic [7:0]  stack_q [4];
   logic [7:0]  stack_d [4];
`endif

   logic [3:0]  op;
   logic [7:0]  imm;

   assign op  = ir_q[15:12];
   assign imm = ir_q[7:0];

   always_comb begin
      // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latch).
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      z_d          = z_q;
      c_d          = c_q;
      instr_req_d  = 1'b0;
      alu_opcode_d = alu_opcode_q;
      ra_addr_d    = ra_addr_q;
      rb_addr_d    = rb_addr_q;
      write_addr_d = 4'd0;
      write_data_d = 8'd0;
      wb_sel_d     = 1'b0;
      write_en_d   = 1'b0;
      halted_d     = 1'b0;
`ifdef DATAPATH_CTRL_CALL_EN
      sp_d         = sp_q;
      stack_d      = stack_q;
`endif

      case (state_q)
         S_FETCH: begin
            // instr_valid only counts once the request is actually visible outside
            if (instr_req_q && instr_valid) begin
               ir_d         = instr_data;
               pc_d         = pc_q + 8'd1;
               state_d      = S_DECODE;
               alu_opcode_d = instr_data[14:12];
               ra_addr_d    = instr_data[7:4];
               rb_addr_d    = instr_data[3:0];
            end else begin
               instr_req_d  = 1'b1;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
            if (op[3] || op == OP_LDI) begin
               write_en_d   = 1'b1;
               write_addr_d = ir_q[11:8];
            end
            if (op == OP_LDI) begin
               wb_sel_d     = 1'b1;
               write_data_d = imm;
            end
         end
         S_EXEC: begin
            state_d     = S_FETCH;
            instr_req_d = 1'b1;
            if (op[3]) begin
               z_d = alu_zero;
               c_d = alu_carry;
            end else begin
               case (op)
                  OP_JMP:  pc_d = imm;
                  OP_JZ:   if (z_q) pc_d = imm;
                  OP_JC:   if (c_q) pc_d = imm;
                  OP_HALT: begin
                     state_d     = S_HALT;
                     instr_req_d = 1'b0;
                     halted_d    = 1'b1;
                  end
`ifdef DATAPATH_CTRL_CALL_EN
                  OP_CALL: begin
                     // pc_q already points past the CALL, so it is the return address
                     if (sp_q == 3'd4) begin
                        stack_d[3] = pc_q;
                     end else begin
                        stack_d[sp_q[1:0]] = pc_q;
                        sp_d = sp_q + 3'd1;
                     end
                     pc_d = imm;
                  end
                  OP_RET: begin
                     if (sp_q != 3'd0) begin
                        pc_d = stack_q[sp_q[1:0] - 2'd1];
                        sp_d = sp_q - 3'd1;
                     end
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_HALT: halted_d = 1'b1;
         default: state_d = S_FETCH;
      endcase
   end

   // NOTE: the return stack array carries no reset; sp_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FETCH;
         pc_q         <= 8'd0;
         ir_q         <= 16'd0;
         z_q          <= 1'b0;
         c_q          <= 1'b0;
         instr_req_q  <= 1'b0;
         alu_opcode_q <= 3'd0;
         ra_addr_q    <= 4'd0;
         rb_addr_q    <= 4'd0;
         write_addr_q <= 4'd0;
         write_data_q <= 8'd0;
         wb_sel_q     <= 1'b0;
         write_en_q   <= 1'b0;
         halted_q     <= 1'b0;
`ifdef DATAPATH_CTRL_CALL_EN
         sp_q         <= 3'd0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         z_q          <= z_d;
         c_q          <= c_d;
         instr_req_q  <= instr_req_d;
         alu_opcode_q <= alu_opcode_d;
         ra_addr_q    <= ra_addr_d;
         rb_addr_q    <= rb_addr_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         wb_sel_q     <= wb_sel_d;
         write_en_q   <= write_en_d;
         halted_q     <= halted_d;
`ifdef DATAPATH_CTRL_CALL_EN
         sp_q         <= sp_d;
`endif
      end
`ifdef DATAPATH_CTRL_CALL_EN
      stack_q <= stack_d;
`endif
   end

   assign instr_req  = instr_req_q;
   assign instr_addr = pc_q;
   assign alu_opcode = alu_opcode_q;
   assign ra_addr    = ra_addr_q;
   assign rb_addr    = rb_addr_q;
   assign write_addr = write_addr_q;
   assign write_data = write_data_q;
   assign wb_sel     = wb_sel_q;
   assign write_en   = write_en_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: an ISA-level model predicts fetch addresses and register
// writes; a memory responder and a small register-file/ALU datapath play the environment.
`timescale 1ns/1ps
module tb_datapath_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [7:0]  instr_addr;
   logic        instr_valid;
   logic [15:0] instr_data;
   logic        alu_zero;
   logic        alu_carry;
   logic [2:0]  alu_opcode;
   logic [3:0]  ra_addr;
   logic [3:0]  rb_addr;
   logic [3:0]  write_addr;
   logic [7:0]  write_data;
   logic        wb_sel;
   logic        write_en;
   logic        halted;

   always #5 clk = ~clk;

   datapath_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .alu_zero    (alu_zero),
      .alu_carry   (alu_carry),
      .alu_opcode  (alu_opcode),
      .ra_addr     (ra_addr),
      .rb_addr     (rb_addr),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .wb_sel      (wb_sel),
      .write_en    (write_en),
      .halted      (halted)
   );

   typedef struct packed {
      logic [3:0] addr;
      logic       wb;
      logic [7:0] data;
   } wr_t;

   logic [15:0] mem [256];
   logic [7:0]  exp_fetch_q [$];
   wr_t         exp_wr_q [$];
   int          dly_q [$];

   int     n_checks = 0;
   int     n_errors = 0;
   int     fetch_budget = 0;
   int     fixed_delay = 0;
   int     cur_delay = 0;
   int     wait_cnt = 0;
   longint cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_evt(input string name, input logic [63:0] act);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, act, $time);
   endtask

   // Datapath semantics chosen by the bench: op 1 = SUB with borrow as carry, as used by the program tests.
   function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    alu_fn = {1'b0, a} + {1'b0, b};
         3'd1:    alu_fn = {a < b, a - b};
         3'd2:    alu_fn = {1'b0, a & b};
         3'd3:    alu_fn = {1'b0, a | b};
         3'd4:    alu_fn = {1'b0, a ^ b};
         3'd5:    alu_fn = {a[0], 1'b0, a[7:1]};
         3'd6:    alu_fn = {a[7], a[6:0], 1'b0};
         default: alu_fn = {1'b0, ~a};
      endcase
   endfunction

   function automatic int pick_delay();
      if (fixed_delay >= 0) return fixed_delay;
      return int'($urandom_range(0, 3));
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Environment datapath: register file written by the DUT strobes, ALU flags fed back.
   logic [7:0] dp_rf [16];
   logic [8:0] dp_alu;
   always_comb dp_alu = alu_fn(alu_opcode, dp_rf[ra_addr], dp_rf[rb_addr]);
   assign alu_carry = dp_alu[8];
   assign alu_zero  = (dp_alu[7:0] == 8'd0);
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) dp_rf[i] <= 8'd0;
      end else if (write_en) begin
         dp_rf[write_addr] <= wb_sel ? write_data : dp_alu[7:0];
      end
   end

   // Instruction memory responder; toggles junk on instr_valid whenever no request is up.
   initial begin
      instr_valid = 1'b0;
      instr_data  = 16'd0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) wait_cnt = 0;
         if (instr_req && !rst) begin
            if (fetch_budget > 0 && wait_cnt >= cur_delay) begin
               instr_valid = 1'b1;
               instr_data  = mem[instr_addr];
               dly_q.push_back(cur_delay);
               fetch_budget--;
               wait_cnt  = 0;
               cur_delay = pick_delay();
            end else begin
               instr_valid = 1'b0;
               instr_data  = 16'($urandom);
               wait_cnt++;
            end
         end else begin
            instr_valid = 1'($urandom_range(0, 1));
            instr_data  = 16'($urandom);
         end
      end
   end

   // Monitor: pops expectations whenever the DUT completes a fetch or strobes a write.
   logic   mon_hs;
   logic   prev_req = 1'b0;
   logic   prev_hs = 1'b0;
   logic   prev_rst = 1'b1;
   logic   hs_first = 1'b1;
   logic [7:0] prev_addr = 8'd0;
   longint last_hs = 0;
   int     mon_d;
   wr_t    mon_w;

   always @(negedge clk) begin
      mon_hs = instr_req && instr_valid && !rst;
      if (rst) begin
         hs_first = 1'b1;
         dly_q.delete();
      end
      if (!rst && !prev_rst && prev_req && !prev_hs)
         check("stall_hold", 64'({instr_req, instr_addr}), 64'({1'b1, prev_addr}));
      if (mon_hs) begin
         if (exp_fetch_q.size() == 0) fail_evt("fetch_extra", 64'(instr_addr));
         else check("fetch_addr", 64'(instr_addr), 64'(exp_fetch_q.pop_front()));
         if (dly_q.size() != 0) begin
            mon_d = dly_q.pop_front();
            if (!hs_first) check("fetch_gap", 64'(cyc - last_hs), 64'(3 + mon_d));
         end
         hs_first = 1'b0;
         last_hs  = cyc;
      end
      if (write_en && !rst) begin
         if (exp_wr_q.size() == 0) begin
            fail_evt("write_extra", 64'({write_addr, wb_sel, write_data}));
         end else begin
            mon_w = exp_wr_q.pop_front();
            check("wr_addr", 64'(write_addr), 64'(mon_w.addr));
            check("wr_sel", 64'(wb_sel), 64'(mon_w.wb));
            if (mon_w.wb) check("wr_data", 64'(write_data), 64'(mon_w.data));
         end
      end
      prev_req  = instr_req;
      prev_addr = instr_addr;
      prev_hs   = mon_hs;
      prev_rst  = rst;
   end

   // ISA-level reference: walks the program from reset and queues every fetch and write.
   task automatic model_run(input int max_instr, output int n_fetch, output bit halts);
      logic [7:0]  pc;
      logic [7:0]  rf [16];
      logic        z, c;
      logic [15:0] ins;
      logic [3:0]  op;
      logic [8:0]  r;
      logic [7:0]  stk [$];
      wr_t         w;
      pc = 8'd0; z = 1'b0; c = 1'b0; n_fetch = 0; halts = 1'b0;
      for (int i = 0; i < 16; i++) rf[i] = 8'd0;
      for (int i = 0; i < max_instr && !halts; i++) begin
         ins = mem[pc];
         exp_fetch_q.push_back(pc);
         n_fetch++;
         pc = pc + 8'd1;
         op = ins[15:12];
         if (op[3]) begin
            r = alu_fn(op[2:0], rf[ins[7:4]], rf[ins[3:0]]);
            rf[ins[11:8]] = r[7:0];
            z = (r[7:0] == 8'd0);
            c = r[8];
            w.addr = ins[11:8]; w.wb = 1'b0; w.data = 8'd0;
            exp_wr_q.push_back(w);
         end else begin
            case (op)
               4'h1: begin
                  rf[ins[11:8]] = ins[7:0];
                  w.addr = ins[11:8]; w.wb = 1'b1; w.data = ins[7:0];
                  exp_wr_q.push_back(w);
               end
               4'h2: pc = ins[7:0];
               4'h3: if (z) pc = ins[7:0];
               4'h4: if (c) pc = ins[7:0];
               4'h7: halts = 1'b1;
`ifdef DATAPATH_CTRL_CALL_EN
               4'h5: begin
                  if (stk.size() == 4) stk[3] = pc;
                  else stk.push_back(pc);
                  pc = ins[7:0];
               end
               4'h6: if (stk.size() > 0) pc = stk.pop_back();
`endif
               default: ;
            endcase
         end
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   // Resets the DUT (wherever it is), runs the model, then lets the DUT execute the same program.
   task automatic run_prog(input int max_instr, input int dly);
      int n_fetch;
      bit halts;
      bit done;
      int bad;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 64'({instr_req, instr_addr, alu_opcode, ra_addr, rb_addr,
                                  write_addr, write_data, wb_sel, write_en, halted}), 64'd0);
      exp_fetch_q.delete();
      exp_wr_q.delete();
      fixed_delay = dly;
      cur_delay   = pick_delay();
      model_run(max_instr, n_fetch, halts);
      fetch_budget = n_fetch;
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("req_after_reset", 64'(instr_req), 64'd1);
      done = 1'b0;
      for (int t = 0; t < max_instr * 12 + 40; t++) begin
         if (exp_fetch_q.size() == 0 && exp_wr_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!done) fail_evt("timeout_pending", 64'(exp_fetch_q.size() + exp_wr_q.size()));
      repeat (4) @(negedge clk);
      if (halts) begin
         check("halted", 64'(halted), 64'd1);
         bad = 0;
         repeat (10) begin
            @(negedge clk);
            if (instr_req || write_en || !halted) bad++;
         end
         check("halt_hold", 64'(bad), 64'd0);
      end else begin
         check("not_halted", 64'(halted), 64'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      clear_mem();
      repeat (3) @(posedge clk);

      // LDI r1,5; LDI r2,5; SUB r3,r1,r2; JZ 0x10; HALT at 0x10 (zero-stall, 3-cycle instructions)
      clear_mem();
      mem[8'h00] = 16'h1105;
      mem[8'h01] = 16'h1205;
      mem[8'h02] = 16'h9312;
      mem[8'h03] = 16'h3010;
      mem[8'h10] = 16'h7000;
      run_prog(20, 0);

      // JC not taken out of reset (C=0)
      clear_mem();
      mem[8'h00] = 16'h4020;
      mem[8'h01] = 16'h7000;
      run_prog(20, -1);

      // Three stall cycles on every fetch: each instruction takes 6 cycles
      clear_mem();
      mem[8'h05] = 16'h7000;
      run_prog(20, 3);

      // Set Z=C=1, jump to 0x07 and leave that fetch stalled, then reset mid-stall
      clear_mem();
      mem[8'h00] = 16'h1180;
      mem[8'h01] = 16'h8211;
      mem[8'h02] = 16'h2007;
      mem[8'h07] = 16'h7000;
      run_prog(3, 0);
      check("stall_at_07", 64'({instr_req, instr_addr}), 64'({1'b1, 8'h07}));
      clear_mem();
      mem[8'h00] = 16'h3030;
      mem[8'h01] = 16'h4031;
      mem[8'h02] = 16'h7000;
      run_prog(20, -1);

      // PC wrap: JMP 0xFF, NOP at 0xFF, fetch wraps to 0x00, then JZ takes us to HALT
      clear_mem();
      mem[8'h00] = 16'h3005;
      mem[8'h01] = 16'h9000;
      mem[8'h02] = 16'h20FF;
      mem[8'hFF] = 16'h0000;
      mem[8'h05] = 16'h7000;
      run_prog(20, -1);

      // CALL 0x40 at 0x03, RET at 0x40
      clear_mem();
      mem[8'h03] = 16'h5040;
      mem[8'h04] = 16'h7000;
      mem[8'h40] = 16'h6000;
      run_prog(20, -1);

      // Random programs with random fetch latency
      for (int p = 0; p < 10; p++) begin
         for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
         run_prog(80, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset; synchronous and active-high.
REQ-003 instr_req  out  1  instruction fetch request.
REQ-004 instr_addr  out  8  fetch address, equal to the PC.
REQ-005 instr_valid  in  1  instr_data valid; honoured only while instr_req=1.
REQ-006 instr_data  in  16  instruction word.
REQ-007 alu_zero, alu_carry  in  1 each  datapath ALU flags.
REQ-008 alu_opcode  out  3  datapath ALU operation select.
REQ-009 ra_addr, rb_addr, write_addr  out  4 each  register file addresses.
REQ-010 write_data  out  8  immediate write value.
REQ-011 wb_sel  out  1  writeback source: 1=write_data, 0=ALU result.
REQ-012 write_en  out  1  register write strobe.
REQ-013 halted  out  1  high while in HALT.

Function
REQ-014 Instruction format SHALL be: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb; imm=[7:0].
REQ-015 Decode when op[3]=1 SHALL be ALU: alu_opcode=op[2:0], rd = ra op rb.
REQ-016 Decode when op[3]=0 SHALL be: 0000 NOP, 0001 LDI rd,imm, 0010 JMP imm, 0011 JZ imm, 0100 JC imm, 0111 HALT; 0101/0110 per REQ-030/031; any other op SHALL execute as NOP.
REQ-017 FSM states SHALL be FETCH, DECODE, EXEC, HALT.
REQ-018 FETCH SHALL hold instr_req=1 and instr_addr=PC until instr_valid=1, then latch IR, set PC=PC+1 (8-bit wrap, 0xFF->0x00), and go to DECODE.
REQ-019 DECODE SHALL drive ra_addr, rb_addr, and alu_opcode from IR, then go to EXEC.
REQ-020 EXEC ALU SHALL pulse write_en=1 for exactly one cycle with write_addr=rd and wb_sel=0, SHALL latch alu_zero/alu_carry into the internal flags Z/C, then go to FETCH.
REQ-021 EXEC LDI SHALL pulse write_en=1 with write_addr=rd, wb_sel=1, and write_data=imm; flags SHALL be unchanged.
REQ-022 EXEC JMP SHALL set PC=imm; JZ SHALL set PC=imm when Z=1 and JC when C=1, otherwise PC is unchanged.
REQ-023 EXEC HALT SHALL enter HALT; HALT SHALL keep instr_req=0 and write_en=0 and SHALL exit only via rst.
REQ-024 Latency SHALL be 3 cycles per instruction when instr_valid returns in the first FETCH cycle; each stall cycle adds 1.
REQ-025 write_en SHALL be 0 in every state except EXEC of ALU or LDI.
REQ-026 ra_addr, rb_addr, and alu_opcode SHALL stay stable from DECODE through EXEC.
REQ-027 instr_valid while instr_req=0 SHALL be ignored.

Reset
REQ-028 rst=1 at any state, including mid-FETCH stall, SHALL force on the next edge: state=FETCH, PC=0, IR=0, Z=C=0, all outputs 0, and return stack pointer=0.
REQ-029 instr_req SHALL assert in the first cycle after rst deasserts.

Configuration
REQ-030 With DATAPATH_CTRL_CALL_EN defined: op 0101 CALL imm SHALL push PC onto a 4-entry return stack and set PC=imm; pushing when full SHALL overwrite the top entry.
REQ-031 With DATAPATH_CTRL_CALL_EN defined: op 0110 RET SHALL pop into PC; popping when empty SHALL leave PC unchanged.
REQ-032 Without DATAPATH_CTRL_CALL_EN: ops 0101 and 0110 SHALL execute as NOP and no stack logic SHALL be present.

Verification
REQ-033 Program LDI r1,0x05; LDI r2,0x05; SUB(op 1001) r3,r1,r2; JZ 0x10 -> two write_en pulses with wb_sel=1 and data 0x05; the SUB write has write_addr=3 and wb_sel=0; Z=1; next instr_addr=0x10.
REQ-034 JC 0x20 executed with C=0 -> next instr_addr is the following PC; no write_en pulse.
REQ-035 instr_valid delayed 3 cycles in FETCH -> instr_req and instr_addr held constant; the instruction completes in 6 cycles.
REQ-036 rst asserted during a FETCH stall at PC=0x07 -> next cycle instr_addr=0x00, write_en=0, and Z=C=0.
REQ-037 Program JMP 0xFF, then NOP at 0xFF -> the following fetch is at 0x00; a HALT fetched next -> halted=1 and instr_req stays 0 for 10 cycles.
REQ-038 With DATAPATH_CTRL_CALL_EN: CALL 0x40 at 0x03, then RET at 0x40 -> next fetch at 0x04; without the macro, CALL acts as NOP and the next fetch is at 0x04.
